button_debouncer: RTL and testbench
===================================

Name: button_debouncer

Overview:
Multi-channel front end for the push-button interrupt peripherals. Each raw, asynchronous, bouncing pad input is synchronised and filtered here. The block produces a clean level, which drives the button peripheral's `in` and its rising-edge interrupt detection, plus one-cycle press and release pulses for polled software status. There is one instance per button bank, directly upstream of the button interrupt sources in the daisy chain.

Parameters:
CHANNELS, 4, number of independent button channels.
SYNC_STAGES, 2, flip-flops in each input synchroniser chain; must be >= 2.
DEBOUNCE_CYCLES, 16, consecutive differing samples (tick cycles) required to commit a change; must be >= 2.
ACTIVE_LOW, 1, 1 means a pad reads 0 when pressed (pull-up); the polarity is corrected inside the block.

Ports:
clock  input  1  system clock; all state on posedge.
reset_n  input  1  asynchronous, active-low reset.
tick  input  1  sample enable from the prescaler; tie to 1 to count in clocks.
raw  input  CHANNELS  pad inputs, asynchronous to clock.
level  output  CHANNELS  debounced pressed state (1 = pressed); feeds the button `in` port.
rise  output  CHANNELS  one-cycle pulse in the cycle `level` goes 0->1.
fall  output  CHANNELS  one-cycle pulse in the cycle `level` goes 1->0.
busy  output  CHANNELS  1 while the channel is in a CHECK state.

Behaviour:
- Synchroniser: per channel, SYNC_STAGES-deep flop chain on every clock, regardless of tick. The sample s = last stage XOR ACTIVE_LOW, so 1 = pressed.
- Reset (asynchronous assert, synchronous release):
  - synchroniser flops load the released value, so s = 0;
  - every channel FSM goes to STABLE_LOW with counter 0;
  - level, rise, fall and busy all = 0.
- Per-channel FSM with states STABLE_LOW, CHECK_HIGH, STABLE_HIGH, CHECK_LOW. It evaluates only on edges where tick = 1 and holds all state otherwise.
  - STABLE_LOW, s=1: go to CHECK_HIGH, cnt <= 1. With s=0: stay.
  - CHECK_HIGH, s=0: go to STABLE_LOW, cnt <= 0. No output change.
  - CHECK_HIGH, s=1 and cnt == DEBOUNCE_CYCLES-1: go to STABLE_HIGH, cnt <= 0, level <= 1, rise <= 1.
  - CHECK_HIGH, s=1 otherwise: cnt <= cnt+1.
  - STABLE_HIGH and CHECK_LOW mirror the above with s inverted, committing level <= 0 and fall <= 1.
- Counter: width $clog2(DEBOUNCE_CYCLES). It never wraps, because the commit occurs at DEBOUNCE_CYCLES-1.
- Outputs are registered.
  - rise and fall are high for exactly one clock, then cleared on the next edge even if tick = 0.
  - rise and fall are never both high on one channel.
  - busy = 1 exactly in the CHECK states.
- Latency with tick = 1: a raw change held steady is first captured at edge 0, and level and the pulse update at edge SYNC_STAGES + DEBOUNCE_CYCLES - 1 (17 with defaults). Any reversion of s during CHECK restarts the full count.
- Channels are fully independent; simultaneous events on several channels commit in the same cycle.
- Reset mid-CHECK: the partial count is discarded and no pulse is generated.
- Button held through reset release: s becomes 1 after the synchroniser fills, and a normal rise follows after the full latency. This is intended, so a held button raises an interrupt once.
- Glitches shorter than one tick period between ticks are not seen by the FSM. This is acceptable by design.
- Parameter violations (SYNC_STAGES < 2, DEBOUNCE_CYCLES < 2) trigger an elaboration-time $error.

Test Plan:
- Defaults, tick=1, raw=4'hF held through reset and 50 cycles after release -> level=0, rise=fall=busy=0 throughout.
- raw[0] driven 0 and held -> busy[0]=1 from edge 2; level[0]=1 with a single-cycle rise[0]=1 at edge 17; channels 1-3 stay idle.
- raw[1] low 10 cycles, high 3, low held -> no rise at edge 17; rise[1] at edge 17 counted from the final falling transition; busy[1] drops for the reversion.
- Press committed on ch0, then raw[0] back to 1 held -> fall[0] pulse and level[0]=0 exactly 17 edges after the release capture; rise[0] stays 0.
- raw[2] and raw[3] driven 0 on the same clock -> rise[2] and rise[3] asserted in the same cycle, level=4'b1100.
- tick every 4th clock, raw[0]=0 -> commit after 16 tick edges. Separately, assert reset_n=0 after 10 cycles in CHECK_HIGH -> level=0 and busy=0 immediately, with no pulse; after release a full count is required.

Source files
------------

// File: rtl/button_debouncer_if.sv
// Button bank signal bundle: prescaler tick and raw pads in, debounced state out.
// master drives tick/raw and observes results; slave is the debouncer itself.
interface button_debouncer_if #(
  parameter int CHANNELS = 4
);
  logic                tick;
  logic [CHANNELS-1:0] raw;
  logic [CHANNELS-1:0] level;
  logic [CHANNELS-1:0] rise;
  logic [CHANNELS-1:0] fall;
  logic [CHANNELS-1:0] busy;

  modport master (
    output tick, raw,
    input  level, rise, fall, busy
  );

  modport slave (
    input  tick, raw,
    output level, rise, fall, busy
  );
endinterface

// File: rtl/button_debouncer.sv
// Multi-channel push-button synchroniser and debouncer with press/release pulses.
// Ports: clock, reset_n (async low), bus (slave): tick, raw in; level, rise, fall, busy out.
module button_debouncer #(
  parameter int CHANNELS        = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input logic               clock,
  input logic               reset_n,
  button_debouncer_if.slave bus
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("button_debouncer: SYNC_STAGES must be >= 2");
  end
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_deb
    $error("button_debouncer: DEBOUNCE_CYCLES must be >= 2");
  end

  typedef enum logic [1:0] {
    ST_LOW,
    CHK_HIGH,
    ST_HIGH,
    CHK_LOW
  } state_e;

  logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
  logic [CHANNELS-1:0] sync_d [SYNC_STAGES];
  logic [CHANNELS-1:0] s;

  state_e              state_q [CHANNELS];
  state_e              state_d [CHANNELS];
  logic [CW-1:0]       cnt_q   [CHANNELS];
  logic [CW-1:0]       cnt_d   [CHANNELS];
  logic [CHANNELS-1:0] level_q, level_d;
  logic [CHANNELS-1:0] rise_q, rise_d;
  logic [CHANNELS-1:0] fall_q, fall_d;
  logic [CHANNELS-1:0] busy_q, busy_d;

  // Synchroniser runs every clock; tick only gates the FSM.
  always_comb begin
    sync_d[0] = bus.raw;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  // Reset value is the released pad level, so s starts at 0.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= {CHANNELS{ACTIVE_LOW}};
      end
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
    end
  end

  assign s = sync_q[SYNC_STAGES-1] ^ {CHANNELS{ACTIVE_LOW}};

  always_comb begin
    level_d = level_q;
    rise_d  = '0;
    fall_d  = '0;
    busy_d  = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      state_d[c] = state_q[c];
      cnt_d[c]   = cnt_q[c];
      if (bus.tick) begin
        unique case (state_q[c])
          ST_LOW: begin
            if (s[c]) begin
              state_d[c] = CHK_HIGH;
              cnt_d[c]   = CNT_ONE;
            end
          end
          CHK_HIGH: begin
            if (!s[c]) begin
              state_d[c] = ST_LOW;
              cnt_d[c]   = '0;
            end else if (cnt_q[c] == CNT_LAST) begin
              state_d[c] = ST_HIGH;
              cnt_d[c]   = '0;
              level_d[c] = 1'b1;
              rise_d[c]  = 1'b1;
            end else begin
              cnt_d[c] = cnt_q[c] + CNT_ONE;
            end
          end
          ST_HIGH: begin
            if (!s[c]) begin
              state_d[c] = CHK_LOW;
              cnt_d[c]   = CNT_ONE;
            end
          end
          CHK_LOW: begin
            if (s[c]) begin
              state_d[c] = ST_HIGH;
              cnt_d[c]   = '0;
            end else if (cnt_q[c] == CNT_LAST) begin
              state_d[c] = ST_LOW;
              cnt_d[c]   = '0;
              level_d[c] = 1'b0;
              fall_d[c]  = 1'b1;
            end else begin
              cnt_d[c] = cnt_q[c] + CNT_ONE;
            end
          end
        endcase
      end
      // Registered busy tracks the state being entered.
      busy_d[c] = (state_d[c] == CHK_HIGH) ||
                  (state_d[c] == CHK_LOW);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < CHANNELS; c++) begin
        state_q[c] <= ST_LOW;
        cnt_q[c]   <= '0;
      end
      level_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      busy_q  <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        state_q[c] <= state_d[c];
        cnt_q[c]   <= cnt_d[c];
      end
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.level = level_q;
  assign bus.rise  = rise_q;
  assign bus.fall  = fall_q;
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer: reset, press, release, bounce,
// simultaneous channels, prescaled tick and reset during a check.
module tb_button_debouncer;

  logic clock;
  logic reset_n;

  button_debouncer_if #(.CHANNELS(4)) bus_if ();

  button_debouncer #(
    .CHANNELS(4),
    .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(16),
    .ACTIVE_LOW(1'b1)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .bus(bus_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp;
  int n_err;
  logic [15:0] got;
  logic [15:0] exp;
  logic [3:0] lv, rs, fl, bs;

  task automatic do_reset();
    reset_n = 1'b0;
    bus_if.raw = 4'hF;
    bus_if.tick = 1'b1;
    @(posedge clock);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus_if.raw = 4'hF;
    bus_if.tick = 1'b1;
    for (int e = 0; e < 3; e++) begin
      @(posedge clock);
      #1;
      got = {bus_if.level, bus_if.rise, bus_if.fall, bus_if.busy};
      n_cmp++;
      if (got !== 16'h0) begin
        n_err++;
        $display("FAIL reset_hold e=%0d got=%h exp=0000", e, got);
      end
    end
    reset_n = 1'b1;
    for (int e = 0; e < 50; e++) begin
      @(posedge clock);
      #1;
      got = {bus_if.level, bus_if.rise, bus_if.fall, bus_if.busy};
      n_cmp++;
      if (got !== 16'h0) begin
        n_err++;
        $display("FAIL reset_idle e=%0d got=%h exp=0000", e, got);
      end
    end
  endtask

  task automatic test_press();
    bus_if.raw = 4'hE;
    for (int e = 0; e <= 20; e++) begin
      @(posedge clock);
      #1;
      lv = (e >= 17) ? 4'b0001 : 4'b0000;
      rs = (e == 17) ? 4'b0001 : 4'b0000;
      fl = 4'b0000;
      bs = (e >= 2 && e <= 16) ? 4'b0001 : 4'b0000;
      exp = {lv, rs, fl, bs};
      got = {bus_if.level, bus_if.rise, bus_if.fall, bus_if.busy};
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL press e=%0d got=%h exp=%h", e, got, exp);
      end
    end
  endtask

  task automatic test_release();
    bus_if.raw = 4'hF;
    for (int e = 0; e <= 20; e++) begin
      @(posedge clock);
      #1;
      lv = (e < 17) ? 4'b0001 : 4'b0000;
      rs = 4'b0000;
      fl = (e == 17) ? 4'b0001 : 4'b0000;
      bs = (e >= 2 && e <= 16) ? 4'b0001 : 4'b0000;
      exp = {lv, rs, fl, bs};
      got = {bus_if.level, bus_if.rise, bus_if.fall, bus_if.busy};
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL release e=%0d got=%h exp=%h", e, got, exp);
      end
    end
  endtask

  task automatic test_bounce();
    bus_if.raw = 4'b1101;
    for (int e = 0; e <= 33; e++) begin
      @(posedge clock);
      #1;
      lv = (e >= 30) ? 4'b0010 : 4'b0000;
      rs = (e == 30) ? 4'b0010 : 4'b0000;
      fl = 4'b0000;
      bs = ((e >= 2 && e <= 11) || (e >= 15 && e <= 29)) ?
           4'b0010 : 4'b0000;
      exp = {lv, rs, fl, bs};
      got = {bus_if.level, bus_if.rise, bus_if.fall, bus_if.busy};
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL bounce e=%0d got=%h exp=%h", e, got, exp);
      end
      bus_if.raw[1] = (e + 1 >= 10 && e + 1 < 13) ? 1'b1 : 1'b0;
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    bus_if.raw = 4'b0011;
    for (int e = 0; e <= 20; e++) begin
      @(posedge clock);
      #1;
      lv = (e >= 17) ? 4'b1100 : 4'b0000;
      rs = (e == 17) ? 4'b1100 : 4'b0000;
      fl = 4'b0000;
      bs = (e >= 2 && e <= 16) ? 4'b1100 : 4'b0000;
      exp = {lv, rs, fl, bs};
      got = {bus_if.level, bus_if.rise, bus_if.fall, bus_if.busy};
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL simul e=%0d got=%h exp=%h", e, got, exp);
      end
    end
  endtask

  task automatic test_tick_prescale();
    do_reset();
    bus_if.raw = 4'hE;
    bus_if.tick = 1'b1;
    for (int e = 0; e <= 68; e++) begin
      @(posedge clock);
      #1;
      lv = (e >= 64) ? 4'b0001 : 4'b0000;
      rs = (e == 64) ? 4'b0001 : 4'b0000;
      fl = 4'b0000;
      bs = (e >= 4 && e <= 63) ? 4'b0001 : 4'b0000;
      exp = {lv, rs, fl, bs};
      got = {bus_if.level, bus_if.rise, bus_if.fall, bus_if.busy};
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL tick e=%0d got=%h exp=%h", e, got, exp);
      end
      bus_if.tick = ((e + 1) % 4 == 0);
    end
    bus_if.tick = 1'b1;
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus_if.raw = 4'hE;
    for (int e = 0; e <= 11; e++) begin
      @(posedge clock);
      #1;
      bs = (e >= 2) ? 4'b0001 : 4'b0000;
      exp = {12'h000, bs};
      got = {bus_if.level, bus_if.rise, bus_if.fall, bus_if.busy};
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL rstmid_pre e=%0d got=%h exp=%h", e, got, exp);
      end
    end
    reset_n = 1'b0;
    #1;
    got = {bus_if.level, bus_if.rise, bus_if.fall, bus_if.busy};
    n_cmp++;
    if (got !== 16'h0) begin
      n_err++;
      $display("FAIL rstmid_async got=%h exp=0000", got);
    end
    for (int e = 0; e < 2; e++) begin
      @(posedge clock);
      #1;
      got = {bus_if.level, bus_if.rise, bus_if.fall, bus_if.busy};
      n_cmp++;
      if (got !== 16'h0) begin
        n_err++;
        $display("FAIL rstmid_hold e=%0d got=%h exp=0000", e, got);
      end
    end
    reset_n = 1'b1;
    for (int e = 0; e <= 20; e++) begin
      @(posedge clock);
      #1;
      lv = (e >= 17) ? 4'b0001 : 4'b0000;
      rs = (e == 17) ? 4'b0001 : 4'b0000;
      fl = 4'b0000;
      bs = (e >= 2 && e <= 16) ? 4'b0001 : 4'b0000;
      exp = {lv, rs, fl, bs};
      got = {bus_if.level, bus_if.rise, bus_if.fall, bus_if.busy};
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL rstmid_post e=%0d got=%h exp=%h", e, got, exp);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset_n = 1'b0;
    bus_if.raw = 4'hF;
    bus_if.tick = 1'b1;
    test_reset();
    test_press();
    test_release();
    test_bounce();
    test_simultaneous();
    test_tick_prescale();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
